// File: rtl/parity_rx_check.sv
// parity_rx_check: deserialises DATA_W data bits plus a trailing parity bit,
// recomputes parity on the fly and reports the word, a one-cycle valid strobe,
// a held mismatch flag and a saturating count of mismatched frames.
module parity_rx_check #(
    parameter int DATA_W = 16,
    parameter bit ODD    = 1'b0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin_valid,
    input  logic              sin,
    input  logic              abort,
    input  logic              clr_count,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              par_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR
    } state_t;

    state_t            state_reg;
    logic [BW-1:0]     bit_cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              par_acc_reg;

    logic frame_done;
    logic par_bad;

    // A frame completes when the parity bit is accepted; abort wins over it.
    assign frame_done = (state_reg == PAR) && sin_valid && !abort;
    // Mismatch between the received parity bit and the running XOR (inverted for odd sense).
    assign par_bad    = sin ^ par_acc_reg ^ ODD;

    // Receive state machine: collects data bits, checks parity, drives registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            par_acc_reg <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (abort) begin
                // Drop the partial frame; completed-frame outputs are left untouched.
                state_reg   <= IDLE;
                bit_cnt_reg <= '0;
                par_acc_reg <= 1'b0;
                busy        <= 1'b0;
            end else if (sin_valid) begin
                case (state_reg)
                    IDLE: begin
                        // First data bit also restarts the running XOR.
                        shift_reg[0] <= sin;
                        par_acc_reg  <= sin;
                        bit_cnt_reg  <= BW'(1);
                        state_reg    <= (DATA_W == 1) ? PAR : DATA;
                        busy         <= 1'b1;
                    end
                    DATA: begin
                        shift_reg[bit_cnt_reg] <= sin;
                        par_acc_reg            <= par_acc_reg ^ sin;
                        bit_cnt_reg            <= bit_cnt_reg + BW'(1);
                        if (bit_cnt_reg == BW'(DATA_W - 1)) begin
                            state_reg <= PAR;
                        end
                    end
                    PAR: begin
                        data_out    <= shift_reg;
                        par_err     <= par_bad;
                        data_valid  <= 1'b1;
                        bit_cnt_reg <= '0;
                        state_reg   <= IDLE;
                        busy        <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating mismatch counter; an error landing with clr_count still counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_count) begin
            err_count <= (frame_done && par_bad) ? CNT_W'(1) : '0;
        end else if (frame_done && par_bad && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_parity_rx_check.sv
// Testbench for parity_rx_check: three instances (even/8-bit count, odd sense,
// 2-bit count) driven by directed frames; a monitor pops expected results
// from per-instance queues whenever data_valid is seen.
module tb_parity_rx_check;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] rst_n;
    logic [2:0] sin_valid;
    logic [2:0] sin;
    logic [2:0] abort;
    logic [2:0] clr_count;

    logic [15:0] data_out0, data_out1, data_out2;
    logic        data_valid0, data_valid1, data_valid2;
    logic        par_err0, par_err1, par_err2;
    logic [7:0]  err_count0, err_count1;
    logic [1:0]  err_count2;
    logic        busy0, busy1, busy2;

    parity_rx_check #(.DATA_W(16), .ODD(1'b0), .CNT_W(8)) u_even (
        .clk(clk), .rst_n(rst_n[0]), .sin_valid(sin_valid[0]), .sin(sin[0]),
        .abort(abort[0]), .clr_count(clr_count[0]), .data_out(data_out0),
        .data_valid(data_valid0), .par_err(par_err0), .err_count(err_count0), .busy(busy0)
    );

    parity_rx_check #(.DATA_W(16), .ODD(1'b1), .CNT_W(8)) u_odd (
        .clk(clk), .rst_n(rst_n[1]), .sin_valid(sin_valid[1]), .sin(sin[1]),
        .abort(abort[1]), .clr_count(clr_count[1]), .data_out(data_out1),
        .data_valid(data_valid1), .par_err(par_err1), .err_count(err_count1), .busy(busy1)
    );

    parity_rx_check #(.DATA_W(16), .ODD(1'b0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n[2]), .sin_valid(sin_valid[2]), .sin(sin[2]),
        .abort(abort[2]), .clr_count(clr_count[2]), .data_out(data_out2),
        .data_valid(data_valid2), .par_err(par_err2), .err_count(err_count2), .busy(busy2)
    );

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          cnt;
        int          edge_n;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic pop_check(input int inst, input logic [15:0] d, input logic e, input int c);
        exp_t x;
        int   n;
        case (inst)
            0:       n = q0.size();
            1:       n = q1.size();
            default: n = q2.size();
        endcase
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL i%0d unexpected_pulse: got data_valid=1 data=%04h required no pulse", inst, d);
            return;
        end
        case (inst)
            0:       x = q0.pop_front();
            1:       x = q1.pop_front();
            default: x = q2.pop_front();
        endcase
        chk($sformatf("i%0d data_out", inst), 32'(d), 32'(x.data));
        chk($sformatf("i%0d par_err", inst), 32'(e), 32'(x.err));
        chk($sformatf("i%0d err_count", inst), 32'(c), 32'(x.cnt));
        chk($sformatf("i%0d pulse_edge", inst), 32'(cyc), 32'(x.edge_n));
    endtask

    // Monitor: every data_valid pulse consumes one expected record.
    always @(negedge clk) begin
        if (data_valid0 === 1'b1) pop_check(0, data_out0, par_err0, int'(err_count0));
        if (data_valid1 === 1'b1) pop_check(1, data_out1, par_err1, int'(err_count1));
        if (data_valid2 === 1'b1) pop_check(2, data_out2, par_err2, int'(err_count2));
    end

    task automatic send_bits(input int inst, input logic [15:0] word, input int nbits, input bit gaps);
        for (int i = 0; i < nbits; i++) begin
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 2));
                repeat (g) begin
                    @(negedge clk);
                    sin_valid[inst] = 1'b0;
                    sin[inst]       = 1'($urandom_range(0, 1));
                    clr_count[inst] = 1'b0;
                end
            end
            @(negedge clk);
            sin_valid[inst] = 1'b1;
            sin[inst]       = word[i];
            clr_count[inst] = 1'b0;
        end
    endtask

    task automatic send_par(input int inst, input logic [15:0] word, input logic par,
                            input logic clr, input logic exp_err, input int exp_cnt);
        exp_t x;
        @(negedge clk);
        sin_valid[inst] = 1'b1;
        sin[inst]       = par;
        clr_count[inst] = clr;
        x.data   = word;
        x.err    = exp_err;
        x.cnt    = exp_cnt;
        x.edge_n = cyc + 1;
        case (inst)
            0:       q0.push_back(x);
            1:       q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endtask

    task automatic idle(input int inst);
        @(negedge clk);
        sin_valid[inst] = 1'b0;
        clr_count[inst] = 1'b0;
        abort[inst]     = 1'b0;
    endtask

    initial begin
        int waited;
        rst_n     = 3'b000;
        sin_valid = 3'b000;
        sin       = 3'b000;
        abort     = 3'b000;
        clr_count = 3'b000;
        repeat (3) @(negedge clk);
        chk("reset data_out", 32'(data_out0), 32'h0);
        chk("reset data_valid", 32'(data_valid0), 32'h0);
        chk("reset par_err", 32'(par_err0), 32'h0);
        chk("reset err_count", 32'(err_count0), 32'h0);
        chk("reset busy", 32'(busy0), 32'h0);
        rst_n = 3'b111;

        // Even parity instance: clean zero word, then bad/good frames back to back.
        send_bits(0, 16'h0000, 16, 1'b0);
        send_par(0, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
        send_bits(0, 16'h8001, 16, 1'b0);
        send_par(0, 16'h8001, 1'b1, 1'b0, 1'b1, 1);
        send_bits(0, 16'h0001, 16, 1'b0);
        send_par(0, 16'h0001, 1'b1, 1'b0, 1'b0, 1);
        idle(0);

        // Gapped partial frame, abort after 9 bits, then a clean frame.
        send_bits(0, 16'h1234, 9, 1'b1);
        idle(0);
        chk("busy before abort", 32'(busy0), 32'h1);
        abort[0]     = 1'b1;
        sin_valid[0] = 1'b1;
        sin[0]       = 1'b1;
        @(negedge clk);
        abort[0]     = 1'b0;
        sin_valid[0] = 1'b0;
        chk("busy after abort", 32'(busy0), 32'h0);
        chk("data_out held by abort", 32'(data_out0), 32'h0001);
        send_bits(0, 16'h00FF, 16, 1'b1);
        send_par(0, 16'h00FF, 1'b0, 1'b0, 1'b0, 1);
        idle(0);

        // Asynchronous reset mid-frame, then a full frame afterwards.
        send_bits(0, 16'h5A3C, 10, 1'b0);
        idle(0);
        chk("busy mid frame", 32'(busy0), 32'h1);
        #2 rst_n[0] = 1'b0;
        #1;
        chk("async rst data_out", 32'(data_out0), 32'h0);
        chk("async rst par_err", 32'(par_err0), 32'h0);
        chk("async rst err_count", 32'(err_count0), 32'h0);
        chk("async rst busy", 32'(busy0), 32'h0);
        chk("async rst data_valid", 32'(data_valid0), 32'h0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        send_bits(0, 16'hA5A5, 16, 1'b0);
        send_par(0, 16'hA5A5, 1'b0, 1'b0, 1'b0, 0);
        idle(0);

        // Odd parity instance.
        send_bits(1, 16'hFFFF, 16, 1'b0);
        send_par(1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0);
        send_bits(1, 16'hFFFF, 16, 1'b0);
        send_par(1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1);
        idle(1);

        // 2-bit counter: saturation, then clear colliding with an error.
        for (int k = 0; k < 5; k++) begin
            send_bits(2, 16'h0000, 16, 1'b0);
            send_par(2, 16'h0000, 1'b1, 1'b0, 1'b1, (k < 3) ? k + 1 : 3);
        end
        send_bits(2, 16'h0000, 16, 1'b0);
        send_par(2, 16'h0000, 1'b1, 1'b1, 1'b1, 1);
        idle(2);
        clr_count[2] = 1'b1;
        @(negedge clk);
        clr_count[2] = 1'b0;
        chk("clr alone err_count", 32'(err_count2), 32'h0);

        // Drain: every expected pulse must appear within a bounded time.
        waited = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_pulses: got %0d outstanding required 0",
                     q0.size() + q1.size() + q2.size());
        end
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
